mem_arbiter: RTL

// - Shares one single-ported RAM between the icache and dcache ports of NCORES cores.
// - Sits between the per-core cache/request-unit logic and the RAM model.
// - Round-robin across cores. Data before instruction within a core.
// - One access outstanding; per-requester wait/load handshake; watchdog on a stuck RAM.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter_rr_picker.sv | 35 +++
 rtl/mem_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the core-to-RAM arbiter: FSM state, grant record, sizing constants.
// Combinational picker and registered FSM both import this.
package mem_arbiter_pkg;

  localparam int ARB_NCORES  = 2;
  localparam int ARB_TIMEOUT = 64;
  localparam int ARB_CNT_W   = $clog2(ARB_TIMEOUT);
  localparam int CORE_W      = (ARB_NCORES > 1) ? $clog2(ARB_NCORES) : 1;

  typedef logic [CORE_W-1:0] core_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef struct packed {
    core_t idx;
    logic  isI;
  } arb_grant_t;

  function automatic core_t next_core(core_t c);
    return (int'(c) == ARB_NCORES - 1) ? '0 : c + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM side signals of the arbiter; arb is the arbiter view, tb the surrounding logic.
// Requests are held stable until the matching wait bit falls.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES = ARB_NCORES
);

  logic [NCORES-1:0]       iREN;
  logic [NCORES-1:0][31:0] iaddr;
  logic [NCORES-1:0]       iwait;
  logic [31:0]             iload;
  logic [NCORES-1:0]       dREN;
  logic [NCORES-1:0]       dWEN;
  logic [NCORES-1:0][31:0] daddr;
  logic [NCORES-1:0][31:0] dstore;
  logic [NCORES-1:0]       dwait;
  logic [31:0]             dload;
  logic                    ramREN;
  logic                    ramWEN;
  logic [31:0]             ramaddr;
  logic [31:0]             ramstore;
  logic [31:0]             ramload;
  logic                    ramready;
  logic                    err;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner search: cores from rr upward (wrapping), data before instruction within a core.
// Zero latency; no backpressure of its own.
module mem_arbiter_rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES = ARB_NCORES
) (
  input  logic [NCORES-1:0][1:0] req,   // [c][0] = data, [c][1] = instruction
  input  core_t                  rr,
  output logic                   valid,
  output arb_grant_t             grant
);

  always_comb begin
    core_t c;
    c     = '0;
    valid = 1'b0;
    grant = '0;
    for (int i = 0; i < NCORES; i++) begin
      c = core_t'((int'(rr) + i) % NCORES);
      if (!valid) begin
        if (req[c][0]) begin
          valid     = 1'b1;
          grant.idx = c;
          grant.isI = 1'b0;
        end else if (req[c][1]) begin
          valid     = 1'b1;
          grant.idx = c;
          grant.isI = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM among the I/D ports of NCORES cores, one access at a time, round-robin.
// Strobe one cycle after grant; wait held until ramready; watchdog aborts after TIMEOUT busy cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES  = ARB_NCORES,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  mem_arbiter_if.arb bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_t              state;
  arb_grant_t              grant;
  core_t                   rr;
  logic                    op_wr;
  logic [CNT_W-1:0]        cnt;
  logic [NCORES-1:0][1:0]  req;
  logic                    pick_vld;
  arb_grant_t              pick;
  logic                    pick_wr;
  logic [31:0]             pick_addr;
  logic [31:0]             pick_store;
  logic                    done;
  logic                    timeout;

  for (genvar c = 0; c < NCORES; c++) begin : g_req
    assign req[c] = {bus.iREN[c], bus.dREN[c] | bus.dWEN[c]};
  end

  mem_arbiter_rr_picker #(.NCORES(NCORES)) u_picker (
    .req   (req),
    .rr    (rr),
    .valid (pick_vld),
    .grant (pick)
  );

  assign pick_wr    = !pick.isI && bus.dWEN[pick.idx];
  assign pick_addr  = pick.isI ? bus.iaddr[pick.idx] : bus.daddr[pick.idx];
  assign pick_store = pick.isI ? 32'h0 : bus.dstore[pick.idx];

  assign done    = (state == ARB_BUSY) && bus.ramready;
  assign timeout = (state == ARB_BUSY) && !bus.ramready && (cnt == CNT_W'(TIMEOUT - 1));
  assign bus.err = timeout;

  // Load data is only forwarded if the requester still wants it; a withdrawn request drops the result.
  always_comb begin
    bus.iwait = bus.iREN;
    bus.dwait = bus.dREN | bus.dWEN;
    bus.iload = '0;
    bus.dload = '0;
    if (done) begin
      if (grant.isI) begin
        bus.iwait[grant.idx] = 1'b0;
        if (bus.iREN[grant.idx]) bus.iload = bus.ramload;
      end else begin
        bus.dwait[grant.idx] = 1'b0;
        if (!op_wr && bus.dREN[grant.idx]) bus.dload = bus.ramload;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      rr           <= '0;
      grant        <= '0;
      op_wr        <= 1'b0;
      cnt          <= '0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          cnt <= '0;
          if (pick_vld) begin
            grant        <= pick;
            op_wr        <= pick_wr;
            bus.ramREN   <= !pick_wr;
            bus.ramWEN   <= pick_wr;
            bus.ramaddr  <= pick_addr;
            bus.ramstore <= pick_store;
            state        <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (bus.ramready || timeout) begin
            // On abort rr is left alone so the same requester is retried first.
            state        <= ARB_IDLE;
            cnt          <= '0;
            bus.ramREN   <= 1'b0;
            bus.ramWEN   <= 1'b0;
            bus.ramaddr  <= '0;
            bus.ramstore <= '0;
            if (bus.ramready) rr <= next_core(grant.idx);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
